// File: rtl/space_inv_pkg.sv
// Shared definitions for the space-invaders projectile movers: fixed-point
// scaling, field widths and the bomb mover state encoding.
package space_inv_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FP_SHIFT               = 6;
    localparam int PIX_W                  = 11;
    localparam int YFP_W                  = 16;
    localparam int BOMB_Y_LIMIT           = 463;

    typedef enum logic [1:0] {
        IDLE_ST,
        COLLECT_ST,
        SOF_ST,
        UPDATE_ST
    } bomb_state_t;

    function automatic logic [PIX_W-1:0] fp_to_pix(input logic [YFP_W-1:0] v);
        return PIX_W'(v >> FP_SHIFT);
    endfunction

endpackage

// File: rtl/bomb_slot_alloc.sv
// Combinational priority encoder: lowest inactive bomb slot plus a found flag.
module bomb_slot_alloc #(
    parameter  int NUM_BOMBS = 4,
    localparam int IDX_W     = $clog2(NUM_BOMBS)
) (
    input  logic [NUM_BOMBS-1:0] i_active,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_idx
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
            if (!i_active[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alien_bomb_move.sv
// Alien bomb pool: accepts drop requests, moves active bombs down once per
// frame in 1/64-pixel fixed point and retires them on hits or screen exit.
module alien_bomb_move
    import space_inv_pkg::*;
#(
    parameter int NUM_BOMBS     = 4,
    parameter int BOMB_SPEED    = 192,
    parameter int FIRE_INTERVAL = 45,
    parameter int Y_LIMIT       = BOMB_Y_LIMIT
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic                       enable_sof,
    input  logic                       launch_req,
    input  logic [PIX_W-1:0]           launch_x,
    input  logic [PIX_W-1:0]           launch_y,
    output logic                       launch_ack,
    input  logic                       hit_ship,
    input  logic                       hit_shield,
    input  logic [2:0]                 hit_slot,
    output logic [NUM_BOMBS-1:0]       bomb_active,
    output logic [PIX_W*NUM_BOMBS-1:0] bomb_x,
    output logic [PIX_W*NUM_BOMBS-1:0] bomb_y,
    output logic                       ship_hit_pulse
);

    localparam int IDX_W = $clog2(NUM_BOMBS);
    localparam int CD_W  = 16;

    bomb_state_t          r_state;
    bomb_state_t          w_next;
    logic [NUM_BOMBS-1:0] r_active;
    logic [NUM_BOMBS-1:0] r_kill;
    logic [PIX_W-1:0]     r_x   [NUM_BOMBS];
    logic [YFP_W-1:0]     r_yfp [NUM_BOMBS];
    logic                 r_ship_flag;
    logic                 r_ack;
    logic                 r_ship_pulse;
    logic [CD_W-1:0]      r_cooldown;
    logic [IDX_W-1:0]     r_slot;

    logic                 w_found;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_launch;
    logic                 w_hit_ok;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_hit_idx;
    logic                 w_last;
    logic [YFP_W-1:0]     w_y_next;

    bomb_slot_alloc #(.NUM_BOMBS(NUM_BOMBS)) u_alloc (
        .i_active (r_active),
        .o_found  (w_found),
        .o_idx    (w_free_idx)
    );

    assign w_hit_idx = hit_slot[IDX_W-1:0];
    assign w_hit_ok  = ({29'd0, hit_slot} < 32'(NUM_BOMBS));
    assign w_launch  = (r_state == COLLECT_ST) && launch_req && enable_sof &&
                       (r_cooldown == '0) && w_found;
    assign w_hit     = (r_state == COLLECT_ST) && (hit_ship || hit_shield) &&
                       w_hit_ok && r_active[w_hit_idx];
    assign w_last    = (r_slot == IDX_W'(NUM_BOMBS - 1));
    assign w_y_next  = r_yfp[r_slot] + YFP_W'(BOMB_SPEED);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE_ST;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE_ST:    if (startOfFrame) w_next = COLLECT_ST;
            COLLECT_ST: if (startOfFrame && enable_sof) w_next = SOF_ST;
            SOF_ST:     w_next = UPDATE_ST;
            UPDATE_ST:  if (w_last) w_next = COLLECT_ST;
            default:    w_next = IDLE_ST;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_active     <= '0;
            r_kill       <= '0;
            r_ship_flag  <= 1'b0;
            r_ack        <= 1'b0;
            r_ship_pulse <= 1'b0;
            r_cooldown   <= '0;
            r_slot       <= '0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                r_x[i]   <= '0;
                r_yfp[i] <= '0;
            end
        end else begin
            r_ack        <= w_launch;
            r_ship_pulse <= 1'b0;
            case (r_state)
                COLLECT_ST: begin
                    if (w_launch) begin
                        r_active[w_free_idx] <= 1'b1;
                        r_x[w_free_idx]      <= launch_x;
                        r_yfp[w_free_idx]    <= YFP_W'(launch_y) * YFP_W'(FIXED_POINT_MULTIPLIER);
                        r_cooldown           <= CD_W'(FIRE_INTERVAL);
                    end
                    // Killed slots stay active until the frame boundary, so
                    // the allocator cannot hand them out again this frame.
                    if (w_hit) begin
                        r_kill[w_hit_idx] <= 1'b1;
                        if (hit_ship) r_ship_flag <= 1'b1;
                    end
                end
                SOF_ST: begin
                    r_active     <= r_active & ~r_kill;
                    r_ship_pulse <= r_ship_flag;
                    r_kill       <= '0;
                    r_ship_flag  <= 1'b0;
                    r_slot       <= '0;
                    if (r_cooldown != '0) r_cooldown <= r_cooldown - 1'b1;
                end
                UPDATE_ST: begin
                    if (r_active[r_slot]) begin
                        r_yfp[r_slot] <= w_y_next;
                        if (fp_to_pix(w_y_next) > PIX_W'(Y_LIMIT)) r_active[r_slot] <= 1'b0;
                    end
                    r_slot <= w_last ? '0 : r_slot + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign launch_ack     = r_ack;
    assign ship_hit_pulse = r_ship_pulse;
    assign bomb_active    = r_active;

    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_out
        assign bomb_x[PIX_W*g +: PIX_W] = r_x[g];
        assign bomb_y[PIX_W*g +: PIX_W] = fp_to_pix(r_yfp[g]);
    end

endmodule

// File: tb/tb_alien_bomb_move.sv
// Scoreboard bench for alien_bomb_move: one instance with the default launch
// interval, one with zero interval for pool-fill and hit scenarios.
module tb_alien_bomb_move;

    localparam int N = 4;

    typedef struct {
        int slot;
        int x;
        int y;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            a_rst_n, a_sof, a_en, a_req, a_ack, a_hship, a_hshield, a_ship;
    logic [2:0]      a_hslot;
    logic [10:0]     a_lx, a_ly;
    logic [N-1:0]    a_act;
    logic [11*N-1:0] a_bx, a_by;

    logic            b_rst_n, b_sof, b_en, b_req, b_ack, b_hship, b_hshield, b_ship;
    logic [2:0]      b_hslot;
    logic [10:0]     b_lx, b_ly;
    logic [N-1:0]    b_act;
    logic [11*N-1:0] b_bx, b_by;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   a_acks = 0, b_acks = 0;
    int   a_pend = 0, b_pend = 0;
    int   n_cmp = 0, n_bad = 0;
    int   fk;

    alien_bomb_move #(.NUM_BOMBS(N), .BOMB_SPEED(192), .FIRE_INTERVAL(45), .Y_LIMIT(463)) dut_a (
        .clk(clk), .resetN(a_rst_n), .startOfFrame(a_sof), .enable_sof(a_en),
        .launch_req(a_req), .launch_x(a_lx), .launch_y(a_ly), .launch_ack(a_ack),
        .hit_ship(a_hship), .hit_shield(a_hshield), .hit_slot(a_hslot),
        .bomb_active(a_act), .bomb_x(a_bx), .bomb_y(a_by), .ship_hit_pulse(a_ship)
    );

    alien_bomb_move #(.NUM_BOMBS(N), .BOMB_SPEED(192), .FIRE_INTERVAL(0), .Y_LIMIT(463)) dut_b (
        .clk(clk), .resetN(b_rst_n), .startOfFrame(b_sof), .enable_sof(b_en),
        .launch_req(b_req), .launch_x(b_lx), .launch_y(b_ly), .launch_ack(b_ack),
        .hit_ship(b_hship), .hit_shield(b_hshield), .hit_slot(b_hslot),
        .bomb_active(b_act), .bomb_x(b_bx), .bomb_y(b_by), .ship_hit_pulse(b_ship)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int f11(input logic [11*N-1:0] v, input int s);
        return int'(v[11*s +: 11]);
    endfunction

    // Monitor: every ack pops the expected slot contents; every ship pulse
    // must be matched by an outstanding expectation.
    always @(negedge clk) begin
        if (a_ack === 1'b1) begin
            a_acks++;
            check("A ack expected", int'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("A ack active", int'(a_act[ea.slot]), 1);
                check("A ack x", f11(a_bx, ea.slot), ea.x);
                check("A ack y", f11(a_by, ea.slot), ea.y);
            end
        end
        if (b_ack === 1'b1) begin
            b_acks++;
            check("B ack expected", int'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("B ack active", int'(b_act[eb.slot]), 1);
                check("B ack x", f11(b_bx, eb.slot), eb.x);
                check("B ack y", f11(b_by, eb.slot), eb.y);
            end
        end
        if (a_ship === 1'b1) begin
            check("A ship pulse expected", int'(a_pend > 0), 1);
            if (a_pend > 0) a_pend--;
        end
        if (b_ship === 1'b1) begin
            check("B ship pulse expected", int'(b_pend > 0), 1);
            if (b_pend > 0) b_pend--;
        end
    end

    task automatic tick(input bit sel);
        @(negedge clk);
        if (!sel && a_ack) a_req = 1'b0;
        if (sel && b_ack)  b_req = 1'b0;
    endtask

    task automatic frame(input bit sel);
        if (sel) b_sof = 1'b1; else a_sof = 1'b1;
        tick(sel);
        if (sel) b_sof = 1'b0; else a_sof = 1'b0;
        repeat (19) tick(sel);
    endtask

    task automatic launch(input bit sel, input int x, input int y, input int slot);
        bit got = 1'b0;
        if (sel) begin
            qb.push_back('{slot, x, y});
            b_lx = 11'(x); b_ly = 11'(y); b_req = 1'b1;
        end else begin
            qa.push_back('{slot, x, y});
            a_lx = 11'(x); a_ly = 11'(y); a_req = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            tick(sel);
            if ((sel ? b_ack : a_ack) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("launch ack within bound", int'(got), 1);
    endtask

    task automatic hit_b(input bit ship, input bit shield, input int slot);
        b_hship = ship; b_hshield = shield; b_hslot = 3'(slot);
        tick(1);
        b_hship = 1'b0; b_hshield = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 1'b0; a_sof = 1'b0; a_en = 1'b1; a_req = 1'b0; a_lx = '0; a_ly = '0;
        a_hship = 1'b0; a_hshield = 1'b0; a_hslot = '0;
        b_rst_n = 1'b0; b_sof = 1'b0; b_en = 1'b1; b_req = 1'b0; b_lx = '0; b_ly = '0;
        b_hship = 1'b0; b_hshield = 1'b0; b_hslot = '0;
        repeat (3) @(negedge clk);

        check("A reset active", int'(a_act), 0);
        check("A reset positions zero", int'(a_bx == '0 && a_by == '0), 1);
        check("A reset ack", int'(a_ack), 0);
        check("A reset ship pulse", int'(a_ship), 0);
        check("B reset active", int'(b_act), 0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Zero-interval instance: fill the pool, bottom exit, hits.
        frame(1);
        launch(1, 10, 460, 0);
        launch(1, 20, 100, 1);
        launch(1, 30, 120, 2);
        launch(1, 40, 140, 3);
        qb.push_back('{0, 77, 300});
        b_lx = 11'd77; b_ly = 11'd300; b_req = 1'b1;
        frame(1);
        check("B pool full no ack", b_acks, 4);
        check("B active full", int'(b_act), 15);
        check("B y0 at limit", f11(b_by, 0), 463);
        frame(1);
        check("B ack after retire", b_acks, 5);
        check("B active refilled", int'(b_act), 15);
        check("B y0 relaunched", f11(b_by, 0), 300);
        check("B x0 relaunched", f11(b_bx, 0), 77);
        check("B y1 moved", f11(b_by, 1), 106);

        b_pend = 1;
        hit_b(1'b1, 1'b0, 2);
        repeat (3) tick(1);
        hit_b(1'b1, 1'b0, 2);
        frame(1);
        check("B active after ship hit", int'(b_act), 11);
        check("B y2 frozen", f11(b_by, 2), 126);
        check("B y1 moved", f11(b_by, 1), 109);
        check("B y0 moved", f11(b_by, 0), 303);
        check("B y3 moved", f11(b_by, 3), 149);
        check("B ship pulse consumed", b_pend, 0);

        hit_b(1'b1, 1'b0, 2);
        tick(1);
        qb.push_back('{2, 55, 200});
        b_lx = 11'd55; b_ly = 11'd200; b_req = 1'b1;
        b_hshield = 1'b1; b_hslot = 3'd1;
        tick(1);
        b_hshield = 1'b0;
        tick(1);
        check("B simultaneous launch ack", b_acks, 6);
        frame(1);
        check("B active after shield hit", int'(b_act), 13);
        check("B y1 frozen", f11(b_by, 1), 109);
        check("B y2 new bomb moved", f11(b_by, 2), 203);
        check("B y0 moved", f11(b_by, 0), 306);

        // Default-interval instance: first launch, cooldown, freeze, reset.
        frame(0);
        launch(0, 100, 50, 0);
        tick(0);
        check("A ack one cycle", int'(a_ack), 0);
        qa.push_back('{1, 200, 10});
        a_lx = 11'd200; a_ly = 11'd10; a_req = 1'b1;
        frame(0);
        check("A y0 after one frame", f11(a_by, 0), 53);
        check("A cooldown blocks ack", a_acks, 1);
        a_en = 1'b0;
        repeat (10) frame(0);
        check("A y0 frozen", f11(a_by, 0), 53);
        check("A no ack while frozen", a_acks, 1);
        a_en = 1'b1;
        fk = -1;
        for (int k = 1; k <= 60; k++) begin
            frame(0);
            if (a_acks == 2) begin
                fk = k;
                break;
            end
        end
        check("A frames until second ack", fk, 44);
        check("A y0 after cooldown", f11(a_by, 0), 185);

        a_sof = 1'b1;
        tick(0);
        a_sof = 1'b0;
        tick(0);
        check("A pre-reset active", int'(a_act), 3);
        a_rst_n = 1'b0;
        #1;
        check("A mid-update reset active", int'(a_act), 0);
        check("A mid-update reset positions", int'(a_bx == '0 && a_by == '0), 1);
        check("A mid-update reset ack", int'(a_ack), 0);
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("A scoreboard drained", qa.size(), 0);
        check("B scoreboard drained", qb.size(), 0);
        check("A ship expectations", a_pend, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alien_bomb_move.md
Name: alien_bomb_move

Overview:
Downward counterpart of the player projectile mover: owns a small pool of alien bombs that drop from the alien formation toward the ship. It accepts launch requests from the alien grid controller with a req/ack handshake and advances every active bomb once per frame in fixed point. It retires bombs on ship hit, shield hit or bottom-of-screen exit, and outputs per-slot positions to the bomb drawing logic.

Parameters:
NUM_BOMBS, 4, number of bomb slots (2..8)
BOMB_SPEED, 192, downward speed in 1/64 pixel per frame (3 px/frame)
FIRE_INTERVAL, 45, minimum frames between two accepted launches
Y_LIMIT, 463, pixel Y beyond which a bomb is retired

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at start of each frame
enable_sof  in  1  0 = freeze movement, cooldown and launches
launch_req  in  1  alien grid requests a drop; held until ack
launch_x  in  11  pixel X of new bomb; stable while req high
launch_y  in  11  pixel Y of new bomb; stable while req high
launch_ack  out  1  one-cycle pulse: request accepted
hit_ship  in  1  drawn bomb pixel overlaps ship this cycle
hit_shield  in  1  drawn bomb pixel overlaps shield this cycle
hit_slot  in  3  slot index of the bomb being drawn (low log2(NUM_BOMBS) bits used)
bomb_active  out  NUM_BOMBS  per-slot valid
bomb_x  out  11*NUM_BOMBS  packed pixel X, slot i at [11i+10:11i]
bomb_y  out  11*NUM_BOMBS  packed pixel Y, same packing
ship_hit_pulse  out  1  one-cycle pulse, at most once per frame

Behaviour:
- Reset (async, any time, including mid-update): state IDLE_ST, all bomb_active=0, positions=0, kill/ship flags=0, cooldown=0, slot counter=0, launch_ack=0, ship_hit_pulse=0.
- Internal Y is 16-bit fixed point (pixel*64). X is held in pixels. Output Y = Yfp>>6. Output X = stored X.
- States:
  - IDLE_ST: wait for first startOfFrame, then go to COLLECT_ST.
  - COLLECT_ST:
    - Launches: if launch_req && enable_sof && cooldown==0 && any slot free, take the lowest free slot. Set its X=launch_x, Yfp=launch_y*64, active=1. Pulse launch_ack on the same edge. Reload cooldown=FIRE_INTERVAL.
    - No ack while req is high and a condition fails; the requester keeps holding.
    - Hits: hit_ship|hit_shield on an active slot sets kill[hit_slot]. hit_ship additionally sets ship_flag. Hits on inactive slots are ignored.
    - startOfFrame && enable_sof → SOF_ST. startOfFrame with enable_sof=0 is ignored.
  - SOF_ST, 1 cycle:
    - active &= ~kill.
    - ship_hit_pulse=ship_flag for this cycle only.
    - Clear kill and ship_flag.
    - cooldown decrements, saturating at 0.
    - slot counter=0 → UPDATE_ST.
  - UPDATE_ST, one slot per cycle, NUM_BOMBS cycles: for an active slot, Yfp += BOMB_SPEED. If the new pixel Y > Y_LIMIT, clear active (Y retained). Inactive slots are untouched. After the last slot → COLLECT_ST.
- Launch, hit and startOfFrame are evaluated only in COLLECT_ST. A launch_req pending during SOF/UPDATE is accepted on the first COLLECT_ST cycle it qualifies.
- Simultaneous launch and hit in the same cycle on different slots: both take effect.
- A slot killed this frame stays active until SOF_ST, so it cannot be relaunched in the same frame.
- Pool full: no ack, cooldown is not reloaded.
- Latency: ack 1 edge after a qualifying req. The new bomb is visible on the same edge. Movement completes within NUM_BOMBS+1 cycles after startOfFrame.

Decomposition:
- Shared package space_inv_pkg: FIXED_POINT_MULTIPLIER=64, FP_SHIFT=6, screen limits, bomb_state_t enum.
- Optional sub-module bomb_slot_alloc: combinational priority encoder returning the lowest free index plus a found flag. Instantiated once.

Test Plan:
1. Reset, one startOfFrame, launch_req with x=100,y=50, cooldown 0 → launch_ack pulse 1 cycle; slot0 active, bomb_x0=100, bomb_y0=50; after the next frame bomb_y0=53.
2. Request held immediately after an accepted launch → no ack for 45 frames; ack on the first COLLECT_ST cycle after the 45th decrement.
3. Fill 4 slots with FIRE_INTERVAL=0 in the test config, fifth request → no ack until a slot retires; then ack into that slot index.
4. Slot2 active, hit_ship with hit_slot=2 mid-frame → on the next startOfFrame bomb_active[2]=0 and ship_hit_pulse=1 for exactly 1 cycle. A second hit in the same frame gives no extra pulse.
5. Bomb launched at y=460 → next frame Y=463 stays active; following frame 466>463 → active cleared.
6. enable_sof=0 for 10 startOfFrame pulses → positions, cooldown unchanged and no acks. resetN low during UPDATE_ST → all outputs 0 immediately.
